// File: rtl/rem_pkg.sv
// Shared constants, helpers and types for the streaming modulo-N remainder tracker.
package rem_pkg;

  // Widest remainder supported (N <= 65535).
  localparam int MAX_RW = 16;

  // Zero-extended container for one step's intermediate 2r+b value.
  typedef logic [MAX_RW:0] rem_wide_t;

  function automatic int rem_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic bit rem_params_ok(input int n, input int w);
    return (n >= 2) && (n <= 65535) && (w >= 1) && (w <= 16);
  endfunction

endpackage

// File: rtl/rem_step.sv
// One MSB-first bit of modular accumulation: (2r + b) mod N, valid for r < N.
module rem_step
  import rem_pkg::*;
#(
  parameter int N  = 5,
  parameter int RW = 3
) (
  input  logic [RW-1:0] i_r,
  input  logic          i_b,
  output logic [RW-1:0] o_r
);

  localparam rem_wide_t N_W = rem_wide_t'(N);

  logic [RW:0] w_sum;
  logic        w_ge;

  // 2r+b < 2N, so a single conditional subtract restores r < N.
  assign w_sum = {i_r, i_b};
  assign w_ge  = rem_wide_t'(w_sum) >= N_W;
  assign o_r   = w_ge ? RW'(w_sum - N_W[RW:0]) : w_sum[RW-1:0];

endmodule

// File: rtl/rem_mod_n.sv
// Streaming modulo-N remainder of an MSB-first number arriving W bits per beat.
// Optional per-frame beat counter enabled by defining REM_BEATCNT_EN.
module rem_mod_n
  import rem_pkg::*;
#(
  parameter int N  = 5,
  parameter int W  = 1,
`ifdef REM_BEATCNT_EN
  parameter int CW = 16,
`endif
  localparam int RW = rem_clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_start,
  input  logic          in_last,
  input  logic [W-1:0]  in_data,
  output logic [RW-1:0] rem,
  output logic          div,
  output logic          out_valid,
  output logic          out_last
`ifdef REM_BEATCNT_EN
  ,
  output logic [CW-1:0] beat_cnt
`endif
);

  if (!rem_params_ok(N, W)) begin : g_bad_params
    $error("rem_mod_n: illegal parameters N=%0d W=%0d", N, W);
  end

  logic [RW-1:0] r_rem;
  logic          r_out_valid;
  logic          r_out_last;
  logic [RW-1:0] w_chain [W+1];

  // A start beat folds its data onto a zero base rather than the held remainder.
  assign w_chain[0] = in_start ? '0 : r_rem;

  for (genvar i = 0; i < W; i++) begin : g_step
    rem_step #(.N(N), .RW(RW)) u_step (
      .i_r (w_chain[i]),
      .i_b (in_data[W-1-i]),
      .o_r (w_chain[i+1])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (in_valid) begin
      r_rem       <= w_chain[W];
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
    end else begin
      if (in_start) r_rem <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

`ifdef REM_BEATCNT_EN
  localparam logic [CW-1:0] CNT_MAX = '1;
  logic [CW-1:0] r_beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (in_valid) begin
      if (in_start)                 r_beat_cnt <= CW'(1);
      else if (r_beat_cnt != CNT_MAX) r_beat_cnt <= r_beat_cnt + CW'(1);
    end else if (in_start) begin
      r_beat_cnt <= '0;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

  assign rem       = r_rem;
  assign div       = (r_rem == '0);
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_rem_mod_n.sv
// Self-checking bench: two instances (N=5,W=1 and N=7,W=4) against a scoreboard model.
module tb_rem_mod_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_valid, a_start, a_last;
  logic [0:0] a_data;
  logic [2:0] a_rem;
  logic       a_div, a_ov, a_ol;
  logic       b_valid, b_start, b_last;
  logic [3:0] b_data;
  logic [2:0] b_rem;
  logic       b_div, b_ov, b_ol;
`ifdef REM_BEATCNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  rem_mod_n #(.N(5), .W(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_start(a_start), .in_last(a_last),
    .in_data(a_data), .rem(a_rem), .div(a_div), .out_valid(a_ov), .out_last(a_ol)
`ifdef REM_BEATCNT_EN
    , .beat_cnt(a_cnt)
`endif
  );

  rem_mod_n #(.N(7), .W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_start(b_start), .in_last(b_last),
    .in_data(b_data), .rem(b_rem), .div(b_div), .out_valid(b_ov), .out_last(b_ol)
`ifdef REM_BEATCNT_EN
    , .beat_cnt(b_cnt)
`endif
  );

  typedef struct {
    int rem;
    bit last;
    int cnt;
  } exp_t;

  localparam int CNT_MAX = 65535;

  exp_t q_a[$];
  exp_t q_b[$];
  int   ma_rem = 0, ma_cnt = 0, mb_rem = 0, mb_cnt = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_model(input int base, input int d, input int n, input int w);
    return (base * (1 << w) + d) % n;
  endfunction

  function automatic int cnt_model(input int cnt, input bit s);
    if (s) return 1;
    return (cnt == CNT_MAX) ? cnt : cnt + 1;
  endfunction

  task automatic drive_a(input bit v, input bit s, input bit l, input bit d);
    exp_t e;
    a_valid = v; a_start = s; a_last = l; a_data = d;
    b_valid = 1'b0; b_start = 1'b0; b_last = 1'b0;
    if (v) begin
      ma_rem = step_model(s ? 0 : ma_rem, int'(d), 5, 1);
      ma_cnt = cnt_model(ma_cnt, s);
      e = '{ma_rem, l, ma_cnt};
      q_a.push_back(e);
    end else if (s) begin
      ma_rem = 0;
      ma_cnt = 0;
    end
    @(posedge clk); #1;
    if (v) begin
      check("a_queue_nonempty", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_out_valid", a_ov, 1);
        check("a_rem", a_rem, e.rem);
        check("a_div", a_div, e.rem == 0);
        check("a_out_last", a_ol, e.last);
`ifdef REM_BEATCNT_EN
        check("a_beat_cnt", a_cnt, e.cnt);
`endif
      end
    end else begin
      check("a_idle_out_valid", a_ov, 0);
      check("a_idle_out_last", a_ol, 0);
      check("a_idle_rem", a_rem, ma_rem);
`ifdef REM_BEATCNT_EN
      check("a_idle_beat_cnt", a_cnt, ma_cnt);
`endif
    end
  endtask

  task automatic drive_b(input bit v, input bit s, input bit l, input logic [3:0] d);
    exp_t e;
    b_valid = v; b_start = s; b_last = l; b_data = d;
    a_valid = 1'b0; a_start = 1'b0; a_last = 1'b0;
    if (v) begin
      mb_rem = step_model(s ? 0 : mb_rem, int'(d), 7, 4);
      mb_cnt = cnt_model(mb_cnt, s);
      e = '{mb_rem, l, mb_cnt};
      q_b.push_back(e);
    end else if (s) begin
      mb_rem = 0;
      mb_cnt = 0;
    end
    @(posedge clk); #1;
    if (v) begin
      check("b_queue_nonempty", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_out_valid", b_ov, 1);
        check("b_rem", b_rem, e.rem);
        check("b_div", b_div, e.rem == 0);
        check("b_out_last", b_ol, e.last);
`ifdef REM_BEATCNT_EN
        check("b_beat_cnt", b_cnt, e.cnt);
`endif
      end
    end else begin
      check("b_idle_out_valid", b_ov, 0);
      check("b_idle_out_last", b_ol, 0);
      check("b_idle_rem", b_rem, mb_rem);
    end
  endtask

  // Reset is asserted alongside live beats on both instances; they must be discarded.
  task automatic do_reset();
    rst = 1'b0;
    a_valid = 1'b1; a_start = 1'b0; a_last = 1'b1; a_data = 1'b1;
    b_valid = 1'b1; b_start = 1'b0; b_last = 1'b1; b_data = 4'hB;
    @(posedge clk); #1;
    rst = 1'b1;
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
    ma_rem = 0; ma_cnt = 0; mb_rem = 0; mb_cnt = 0;
    q_a.delete();
    q_b.delete();
    check("rst_a_rem", a_rem, 0);
    check("rst_a_div", a_div, 1);
    check("rst_a_out_valid", a_ov, 0);
    check("rst_a_out_last", a_ol, 0);
    check("rst_b_rem", b_rem, 0);
    check("rst_b_div", b_div, 1);
    check("rst_b_out_valid", b_ov, 0);
`ifdef REM_BEATCNT_EN
    check("rst_a_beat_cnt", a_cnt, 0);
    check("rst_b_beat_cnt", b_cnt, 0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1'b0; a_start = 1'b0; a_last = 1'b0; a_data = '0;
    b_valid = 1'b0; b_start = 1'b0; b_last = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 13 = 1101b -> 1,3,1,3
    drive_a(1, 1, 0, 1); drive_a(1, 0, 0, 1); drive_a(1, 0, 0, 0); drive_a(1, 0, 1, 1);
    check("t1_final_rem", a_rem, 3);
    check("t1_final_div", a_div, 0);

    // 10 = 1010b -> 1,2,0,0
    drive_a(1, 1, 0, 1); drive_a(1, 0, 0, 0); drive_a(1, 0, 0, 1); drive_a(1, 0, 1, 0);
    check("t2_final_div", a_div, 1);

    // 255 mod 7 in two nibbles -> 1 then 3
    drive_b(1, 1, 0, 4'hF); drive_b(1, 0, 1, 4'hF);
    check("t3_final_rem", b_rem, 3);
    check("t3_final_last", b_ol, 1);

    // Idle gaps mid-frame leave the remainder untouched
    drive_a(1, 1, 0, 1);
    drive_a(0, 0, 0, 1); drive_a(0, 0, 1, 0); drive_a(0, 0, 0, 1);
    drive_a(1, 0, 0, 0); drive_a(1, 0, 1, 1);
    check("t4_final_div", a_div, 1);

    // Restart mid-frame: prior rem 3, start bit 1 gives 1
    drive_a(1, 1, 0, 1); drive_a(1, 0, 0, 1);
    drive_a(1, 1, 0, 1);
    check("t5_restart_rem", a_rem, 1);

    // Idle start clears; single-beat frame; continuing after last
    drive_a(0, 1, 0, 1);
    check("idle_start_div", a_div, 1);
    drive_a(1, 1, 1, 1);
    drive_a(1, 0, 0, 1);
    drive_b(0, 1, 0, 4'h3);
    drive_b(1, 1, 1, 4'h9);
    drive_b(1, 0, 0, 4'h6);

    // Reset mid-frame, then a fresh 3-beat frame (5 -> 1,2,0)
    drive_a(1, 1, 0, 1); drive_a(1, 0, 0, 1);
    drive_b(1, 1, 0, 4'h5);
    do_reset();
    drive_a(1, 1, 0, 1); drive_a(1, 0, 0, 0); drive_a(1, 0, 1, 1);

    for (int i = 0; i < 40; i++)
      drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++)
      drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
